// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: assembles opcode/A/B frames from RX bytes, drives the ALU, returns the result on TX.
// Build option: define ALU_CMD_CARRY_EN to append {7'b0, Carry_OUT} to arithmetic responses.
module alu_cmd_ctrl #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH_A = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int TIMEOUT     = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [7:0]                 RX_DATA,
    input  logic                       RX_VALID,
    output logic signed [IN_WIDTH-1:0] A,
    output logic signed [IN_WIDTH-1:0] B,
    output logic [3:0]                 ALU_FUN,
    input  logic [OUT_WIDTH_A-1:0]     Arith_OUT,
    input  logic [OUT_WIDTH-1:0]       Logic_OUT,
    input  logic [OUT_WIDTH-1:0]       CMP_OUT,
    input  logic [OUT_WIDTH-1:0]       Shift_OUT,
    input  logic                       Carry_OUT,
    input  logic                       Arith_Flag,
    input  logic                       Logic_Flag,
    input  logic                       CMP_Flag,
    input  logic                       Shift_Flag,
    output logic [7:0]                 TX_DATA,
    output logic                       TX_VALID,
    input  logic                       TX_READY,
    output logic                       BUSY,
    output logic [7:0]                 ERR_CNT
);
    localparam int IN_BYTES = IN_WIDTH / 8;
`ifdef ALU_CMD_CARRY_EN
    localparam int ARITH_W = OUT_WIDTH_A + 8;
`else
    localparam int ARITH_W = OUT_WIDTH_A;
`endif
    localparam int SR_W     = (ARITH_W > OUT_WIDTH) ? ARITH_W : OUT_WIDTH;
    localparam int SR_BYTES = SR_W / 8;
    localparam int BC_W     = $clog2(IN_BYTES + 1);
    localparam int LEN_W    = $clog2(SR_BYTES + 1);

    localparam logic [BC_W-1:0]  LAST_LANE  = BC_W'(IN_BYTES - 1);
    localparam logic [3:0]       WAIT_LAST  = 4'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] ARITH_LAST = LEN_W'(ARITH_W / 8 - 1);
    localparam logic [LEN_W-1:0] OTHER_LAST = LEN_W'(OUT_WIDTH / 8 - 1);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, WAIT, SEND} state_t;

    state_t           state;
    logic [BC_W-1:0]  byte_cnt;
    logic [3:0]       wait_cnt;
    logic [LEN_W-1:0] tx_left;
    logic [SR_W-1:0]  tx_sr;

    logic             flag_hit;
    logic [SR_W-1:0]  result;
    logic [LEN_W-1:0] result_last;
    logic             timeout_hit;
    logic             bad_sync;
    logic             overrun;
    logic             err_inc;

`ifndef ALU_CMD_CARRY_EN
    logic unused_carry;
    assign unused_carry = Carry_OUT;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        flag_hit    = 1'b0;
        result      = '0;
        result_last = OTHER_LAST;
        case (ALU_FUN[3:2])
            2'b00: begin
                flag_hit    = Arith_Flag;
`ifdef ALU_CMD_CARRY_EN
                result      = SR_W'({7'b0, Carry_OUT, Arith_OUT});
`else
                result      = SR_W'(Arith_OUT);
`endif
                result_last = ARITH_LAST;
            end
            2'b01: begin
                flag_hit = Logic_Flag;
                result   = SR_W'(Logic_OUT);
            end
            2'b10: begin
                flag_hit = CMP_Flag;
                result   = SR_W'(CMP_OUT);
            end
            default: begin
                flag_hit = Shift_Flag;
                result   = SR_W'(Shift_OUT);
            end
        endcase
    end

    // A timeout and an overrun byte may land in the same WAIT cycle; they count as one error.
    assign timeout_hit = (state == WAIT) && !flag_hit && (wait_cnt == WAIT_LAST);
    assign bad_sync    = RX_VALID && (state == IDLE) && (RX_DATA[7:4] != 4'hA);
    assign overrun     = RX_VALID && ((state == EXEC) || (state == WAIT) || (state == SEND));
    assign err_inc     = bad_sync || overrun || timeout_hit;
    assign BUSY        = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            A        <= '0;
            B        <= '0;
            ALU_FUN  <= '0;
            byte_cnt <= '0;
            wait_cnt <= '0;
            tx_left  <= '0;
            tx_sr    <= '0;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            if (err_inc && (ERR_CNT != 8'hFF))
                ERR_CNT <= ERR_CNT + 8'd1;

            case (state)
                IDLE: begin
                    if (RX_VALID && (RX_DATA[7:4] == 4'hA)) begin
                        ALU_FUN  <= RX_DATA[3:0];
                        byte_cnt <= '0;
                        state    <= GET_A;
                    end
                end
                GET_A: begin
                    if (RX_VALID) begin
                        for (int i = 0; i < IN_BYTES; i++)
                            if (byte_cnt == BC_W'(i)) A[8*i +: 8] <= RX_DATA;
                        if (byte_cnt == LAST_LANE) begin
                            byte_cnt <= '0;
                            state    <= GET_B;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                GET_B: begin
                    if (RX_VALID) begin
                        for (int i = 0; i < IN_BYTES; i++)
                            if (byte_cnt == BC_W'(i)) B[8*i +: 8] <= RX_DATA;
                        if (byte_cnt == LAST_LANE) begin
                            byte_cnt <= '0;
                            state    <= EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (flag_hit) begin
                        TX_DATA  <= result[7:0];
                        tx_sr    <= result >> 8;
                        tx_left  <= result_last;
                        TX_VALID <= 1'b1;
                        state    <= SEND;
                    end else if (wait_cnt == WAIT_LAST) begin
                        TX_DATA  <= 8'hEE;
                        tx_sr    <= '0;
                        tx_left  <= '0;
                        TX_VALID <= 1'b1;
                        state    <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                SEND: begin
                    if (TX_READY) begin
                        if (tx_left == '0) begin
                            TX_VALID <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            TX_DATA <= tx_sr[7:0];
                            tx_sr   <= tx_sr >> 8;
                            tx_left <= tx_left - LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: drives command frames and a timed ALU model, compares TX bytes and error count
// against a byte-queue reference built from the frame rules.
module tb_alu_cmd_ctrl;
    localparam int IN_WIDTH    = 16;
    localparam int OUT_WIDTH_A = 32;
    localparam int OUT_WIDTH   = 16;
    localparam int TIMEOUT     = 4;
    localparam int IN_BYTES    = IN_WIDTH / 8;

    logic                       CLK = 1'b0;
    logic                       RST;
    logic [7:0]                 RX_DATA;
    logic                       RX_VALID;
    logic signed [IN_WIDTH-1:0] A;
    logic signed [IN_WIDTH-1:0] B;
    logic [3:0]                 ALU_FUN;
    logic [OUT_WIDTH_A-1:0]     Arith_OUT;
    logic [OUT_WIDTH-1:0]       Logic_OUT;
    logic [OUT_WIDTH-1:0]       CMP_OUT;
    logic [OUT_WIDTH-1:0]       Shift_OUT;
    logic                       Carry_OUT;
    logic [3:0]                 flag_v;
    logic [7:0]                 TX_DATA;
    logic                       TX_VALID;
    logic                       TX_READY;
    logic                       BUSY;
    logic [7:0]                 ERR_CNT;

    int checks  = 0;
    int errors  = 0;
    int exp_err = 0;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH_A(OUT_WIDTH_A),
        .OUT_WIDTH  (OUT_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .Arith_OUT (Arith_OUT),
        .Logic_OUT (Logic_OUT),
        .CMP_OUT   (CMP_OUT),
        .Shift_OUT (Shift_OUT),
        .Carry_OUT (Carry_OUT),
        .Arith_Flag(flag_v[0]),
        .Logic_Flag(flag_v[1]),
        .CMP_Flag  (flag_v[2]),
        .Shift_Flag(flag_v[3]),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .BUSY      (BUSY),
        .ERR_CNT   (ERR_CNT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic scramble_buses();
        Arith_OUT = $urandom;
        Logic_OUT = OUT_WIDTH'($urandom);
        CMP_OUT   = OUT_WIDTH'($urandom);
        Shift_OUT = OUT_WIDTH'($urandom);
        Carry_OUT = 1'($urandom);
    endtask

    // Called at a falling edge; the byte is sampled at the next rising edge.
    task automatic drive_rx(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] fun, input logic [IN_WIDTH-1:0] a,
                              input logic [IN_WIDTH-1:0] b, input bit gaps);
        drive_rx({4'hA, fun});
        for (int i = 0; i < 2 * IN_BYTES; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
            drive_rx(i < IN_BYTES ? a[8*i +: 8] : b[8*(i-IN_BYTES) +: 8]);
        end
    endtask

    task automatic bad_sync(input logic [7:0] b);
        drive_rx(b);
        bump_err();
        check("bad_sync_busy", BUSY, 1'b0);
        check("bad_sync_tx_valid", TX_VALID, 1'b0);
        check("bad_sync_err_cnt", ERR_CNT, exp_err);
    endtask

    // delay >= TIMEOUT means the selected flag never rises.
    task automatic run_frame(input logic [3:0] fun, input logic [IN_WIDTH-1:0] a,
                             input logic [IN_WIDTH-1:0] b, input int delay,
                             input logic [OUT_WIDTH_A-1:0] ares, input logic [OUT_WIDTH-1:0] lres,
                             input logic [OUT_WIDTH-1:0] cres, input logic [OUT_WIDTH-1:0] sres,
                             input logic carry, input bit stall, input bit inj_exec,
                             input bit inj_send);
        logic [7:0]           exp_q[$];
        logic [OUT_WIDTH-1:0] sel;
        bit                   timed_out;
        bit                   rdy;
        bit                   injected;
        int                   idx;
        int                   cyc;
        int                   stall_left;
        int                   stall_at;

        timed_out = (delay >= TIMEOUT);
        send_frame(fun, a, b, 1'b1);

        // Cycle N+1: EXEC.
        check("exec_busy", BUSY, 1'b1);
        check("exec_a", $unsigned(A), a);
        check("exec_b", $unsigned(B), b);
        check("exec_fun", ALU_FUN, fun);
        check("exec_tx_valid", TX_VALID, 1'b0);
        if (inj_exec) begin
            RX_DATA  = 8'($urandom);
            RX_VALID = 1'b1;
            bump_err();
        end
        @(negedge CLK);
        RX_VALID = 1'b0;

        // Cycles N+2 ...: WAIT, with unrelated flags toggling randomly.
        for (int k = 0; k < TIMEOUT; k++) begin
            bit hit_now;
            bit last_now;
            hit_now  = !timed_out && (k == delay);
            last_now = hit_now || (timed_out && (k == TIMEOUT - 1));
            flag_v   = 4'($urandom);
            flag_v[fun[3:2]] = hit_now;
            if (hit_now) begin
                Arith_OUT = ares;
                Logic_OUT = lres;
                CMP_OUT   = cres;
                Shift_OUT = sres;
                Carry_OUT = carry;
            end else begin
                scramble_buses();
            end
            @(negedge CLK);
            flag_v = '0;
            scramble_buses();
            if (last_now) break;
            check("wait_no_tx", TX_VALID, 1'b0);
        end
        check("first_tx_valid", TX_VALID, 1'b1);

        if (timed_out) begin
            exp_q.push_back(8'hEE);
            bump_err();
        end else if (fun[3:2] == 2'b00) begin
            for (int i = 0; i < OUT_WIDTH_A / 8; i++) exp_q.push_back(ares[8*i +: 8]);
`ifdef ALU_CMD_CARRY_EN
            exp_q.push_back({7'b0, carry});
`endif
        end else begin
            sel = (fun[3:2] == 2'b01) ? lres : (fun[3:2] == 2'b10) ? cres : sres;
            for (int i = 0; i < OUT_WIDTH / 8; i++) exp_q.push_back(sel[8*i +: 8]);
        end

        idx        = 0;
        cyc        = 0;
        injected   = 1'b0;
        stall_at   = (exp_q.size() > 1) ? 1 : 0;
        stall_left = stall ? 10 : 0;
        while (idx < exp_q.size() && cyc < 100) begin
            check("tx_valid", TX_VALID, 1'b1);
            check("tx_data", TX_DATA, exp_q[idx]);
            if (idx == stall_at && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            TX_READY = rdy;
            if (inj_send && !injected && idx == stall_at) begin
                RX_DATA  = 8'($urandom);
                RX_VALID = 1'b1;
                injected = 1'b1;
                bump_err();
            end
            @(negedge CLK);
            RX_VALID = 1'b0;
            if (rdy) idx++;
            cyc++;
        end
        TX_READY = 1'b0;
        check("tx_byte_count", idx, exp_q.size());
        check("done_tx_valid", TX_VALID, 1'b0);
        check("done_busy", BUSY, 1'b0);
        check("done_err_cnt", ERR_CNT, exp_err);
    endtask

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        b = 8'($urandom);
        if (b[7:4] == 4'hA) b[7:4] = 4'h3;
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b0;
        RX_DATA  = '0;
        RX_VALID = 1'b0;
        TX_READY = 1'b0;
        flag_v   = '0;
        Arith_OUT = '0;
        Logic_OUT = '0;
        CMP_OUT   = '0;
        Shift_OUT = '0;
        Carry_OUT = 1'b0;
        repeat (3) @(negedge CLK);

        check("rst_a", $unsigned(A), 0);
        check("rst_b", $unsigned(B), 0);
        check("rst_fun", ALU_FUN, 0);
        check("rst_tx_data", TX_DATA, 0);
        check("rst_tx_valid", TX_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err_cnt", ERR_CNT, 0);
        RST = 1'b1;
        @(negedge CLK);

        // Add, logic, bad sync followed by a good frame, timeout, backpressure with overrun.
        run_frame(4'h0, 16'h0005, 16'h0003, 0, 32'd8, 16'h1234, 16'h5678, 16'h9ABC, 1'b0, 0, 0, 0);
        run_frame(4'h4, 16'h00F0, 16'h0FF0, 0, 32'hDEADBEEF, 16'h00F0, 16'h1111, 16'h2222, 1'b1, 0, 0, 0);
        bad_sync(8'h34);
        run_frame(4'hC, 16'h8001, 16'h7FFE, 2, 32'h01020304, 16'hAAAA, 16'hBBBB, 16'hC3A5, 1'b0, 0, 0, 0);
        run_frame(4'h8, 16'h1234, 16'h4321, TIMEOUT, 32'h0, 16'h0, 16'h0, 16'h0, 1'b0, 0, 0, 0);
        run_frame(4'h1, 16'hFFFF, 16'h0001, 1, 32'hA1B2C3D4, 16'h0, 16'h0, 16'h0, 1'b1, 1, 0, 1);
        run_frame(4'h9, 16'h0042, 16'h0024, TIMEOUT, 32'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1, 1, 1);

        // Reset mid-SEND, between clock edges.
        bad_sync(8'h12);
        send_frame(4'h1, 16'h1357, 16'h2468, 1'b0);
        @(negedge CLK);
        flag_v    = 4'b0001;
        Arith_OUT = 32'h11223344;
        @(negedge CLK);
        flag_v   = '0;
        TX_READY = 1'b1;
        check("pre_rst_byte0", TX_DATA, 8'h44);
        @(negedge CLK);
        TX_READY = 1'b0;
        check("pre_rst_byte1", TX_DATA, 8'h33);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_tx_valid", TX_VALID, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_a", $unsigned(A), 0);
        check("mid_rst_b", $unsigned(B), 0);
        check("mid_rst_fun", ALU_FUN, 0);
        check("mid_rst_tx_data", TX_DATA, 0);
        check("mid_rst_err_cnt", ERR_CNT, 0);
        exp_err = 0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_tx_valid", TX_VALID, 0);
        check("post_rst_busy", BUSY, 0);
        run_frame(4'h5, 16'h0F0F, 16'hF0F0, 0, 32'h0, 16'h5AA5, 16'h0, 16'h0, 1'b0, 0, 0, 0);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) bad_sync(rand_bad());
            run_frame(4'($urandom), IN_WIDTH'($urandom), IN_WIDTH'($urandom),
                      int'($urandom_range(0, TIMEOUT)), $urandom, OUT_WIDTH'($urandom),
                      OUT_WIDTH'($urandom), OUT_WIDTH'($urandom), 1'($urandom),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // Error counter saturation, then a frame still completes.
        repeat (260) begin
            drive_rx(rand_bad());
            bump_err();
        end
        check("err_cnt_saturated", ERR_CNT, exp_err);
        run_frame(4'h2, 16'h0102, 16'h0304, 0, 32'h55667788, 16'h0, 16'h0, 16'h0, 1'b1, 0, 1, 0);
        check("err_cnt_held", ERR_CNT, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
